fetch_issue_buffer: RTL and testbench

//  Parametrised N-lane decoupling queue between fetch and decode; replaces the fixed two-lane IF/ID register pair.

---
 rtl/fib_pkg.sv | 38 +++
 rtl/fib_ram.sv | 37 +++
 rtl/fetch_issue_buffer.sv | 115 +++++++++++
 tb/tb_fetch_issue_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and lane-mask helpers for the fetch/issue decoupling queue.
// Masks are handled at a fixed width of 4, which is the widest supported issue width.
package fib_pkg;

    localparam int FIB_AW = 10;
    localparam int FIB_IW = 32;
    localparam int EW     = 2 * FIB_AW + FIB_IW;

    typedef struct packed {
        logic [FIB_AW-1:0] pc;
        logic [FIB_IW-1:0] instr;
        logic [FIB_AW-1:0] btarget;
    } fib_entry_t;

    // Counts the ones in the unbroken run that starts at lane 0.
    function automatic logic [2:0] lead_ones(input logic [3:0] mask);
        logic [2:0] n;
        logic       run;
        n   = 3'd0;
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (run && mask[i]) begin
                n = n + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // A thermometer mask has the form 0..01..1. An all-zero mask also qualifies.
    function automatic logic is_thermo(input logic [3:0] mask);
        logic [3:0] inc;
        inc = mask + 4'd1;
        return (mask & inc) == 4'd0;
    endfunction

endpackage

// File: rtl/fib_ram.sv
// Entry storage for the fetch/issue queue: multi-port register array.
// One write port and one asynchronous read port per lane, addressed modulo DEPTH.
module fib_ram
    import fib_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = EW,
    parameter int LANES = 2
) (
    input  logic                                  clk,
    input  logic [LANES-1:0]                      wr_en,
    input  logic [LANES-1:0][$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [LANES*DW-1:0]                   wr_data,
    input  logic [$clog2(DEPTH)-1:0]              rd_base,
    output logic [LANES*DW-1:0]                   rd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    // Active lanes always target distinct entries, so port order is irrelevant.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en[l]) begin
                mem[wr_addr[l]] <= wr_data[l*DW +: DW];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
            assign rd_data[gi*DW +: DW] = mem[rd_base + PW'(gi)];
        end
    endgenerate

endmodule

// File: rtl/fetch_issue_buffer.sv
// N-lane in-order decoupling queue between fetch and decode, flushed on redirect.
// Optional macro FIB_BYPASS_EN: when empty, incoming packets are visible to decode in the same cycle.
module fetch_issue_buffer
    import fib_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int DEPTH   = 8,
    parameter int IW      = FIB_IW,
    parameter int AW      = FIB_AW,
    localparam int ENTRY_W = 2 * AW + IW,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*ENTRY_W-1:0]   in_data,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*ENTRY_W-1:0]   out_data,
    input  logic [LANES-1:0]           out_take,
    output logic [CW-1:0]              count,
    output logic                       proto_err
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]              rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]              wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]              count_reg, count_next;
    logic                       proto_err_reg, proto_err_next;

    logic [LANES-1:0]           stored_valid;
    logic [LANES-1:0]           push_mask;
    logic [LANES-1:0]           wr_en;
    logic [LANES-1:0][PW-1:0]   wr_addr;
    logic [LANES*ENTRY_W-1:0]   rd_data;
    logic [2:0]                 npush, npop, skip;
    logic                       push_err, take_err;

    // Depends only on registered occupancy, keeping decode's take off fetch's timing path.
    assign in_ready = count_reg <= CW'(DEPTH - LANES);
    assign npush    = (in_ready && in_valid[0]) ? lead_ones(4'(in_valid)) : 3'd0;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign stored_valid[gi] = count_reg > CW'(gi);
            assign push_mask[gi]    = 3'(gi) < npush;
            // Lanes consumed through the bypass are not stored; the rest pack down from wr_ptr.
            assign wr_en[gi]        = !flush && push_mask[gi] && (3'(gi) >= skip);
            assign wr_addr[gi]      = wr_ptr_reg + PW'(gi) - PW'(skip);
        end
    endgenerate

`ifdef FIB_BYPASS_EN
    logic bypass;

    // in_ready is always high when empty, so no extra qualification is needed.
    assign bypass    = (count_reg == '0) && !flush;
    assign out_valid = bypass ? push_mask : stored_valid;
    assign out_data  = bypass ? in_data : rd_data;
    assign skip      = bypass ? npop : 3'd0;
`else
    assign out_valid = stored_valid;
    assign out_data  = rd_data;
    assign skip      = 3'd0;
`endif

    assign npop     = lead_ones(4'(out_take & out_valid));
    assign push_err = in_ready && !is_thermo(4'(in_valid));
    assign take_err = !is_thermo(4'(out_take)) || (|(out_take & ~out_valid));

    always_comb begin
        rd_ptr_next    = rd_ptr_reg + PW'(npop) - PW'(skip);
        wr_ptr_next    = wr_ptr_reg + PW'(npush) - PW'(skip);
        count_next     = count_reg + CW'(npush) - CW'(npop);
        proto_err_next = proto_err_reg | push_err | take_err;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            proto_err_reg <= proto_err_next;
        end
    end

    fib_ram #(
        .DEPTH (DEPTH),
        .DW    (ENTRY_W),
        .LANES (LANES)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_base (rd_ptr_reg),
        .rd_data (rd_data)
    );

    assign count     = count_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Self-checking bench for fetch_issue_buffer (LANES=2, DEPTH=8): queue scoreboard plus a vector table.
module tb_fetch_issue_buffer;
    import fib_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int EWT   = EW;
`ifdef FIB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush = 1'b0;
    logic [LANES-1:0]       in_valid = '0;
    logic [LANES*EWT-1:0]   in_data = '0;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*EWT-1:0]   out_data;
    logic [LANES-1:0]       out_take = '0;
    logic [3:0]             count;
    logic                   proto_err;

    always #5 clk = ~clk;

    fetch_issue_buffer #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .IW    (FIB_IW),
        .AW    (FIB_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_take  (out_take),
        .count     (count),
        .proto_err (proto_err)
    );

    int              checks = 0;
    int              errors = 0;
    logic [EWT-1:0]  exp_q[$];
    logic            perr = 1'b0;
    logic [FIB_AW-1:0] next_pc = '0;

    typedef struct {
        logic [1:0] v;
        logic [1:0] t;
        logic       f;
        int         cnt;
        logic       rdy;
    } vec_t;

    vec_t tab[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lo2(input logic [1:0] m);
        if (!m[0]) return 0;
        return m[1] ? 2 : 1;
    endfunction

    function automatic logic [1:0] thermo(input int n);
        if (n >= 2) return 2'b11;
        if (n == 1) return 2'b01;
        return 2'b00;
    endfunction

    task automatic apply(input logic [1:0] v, input logic [1:0] t, input logic f);
        fib_entry_t e0, e1;
        e0.pc      = next_pc;
        e0.instr   = $urandom;
        e0.btarget = FIB_AW'($urandom);
        e1.pc      = next_pc + 1'b1;
        e1.instr   = $urandom;
        e1.btarget = FIB_AW'($urandom);
        in_data  = {e1, e0};
        in_valid = v;
        out_take = t;
        flush    = f;
    endtask

    task automatic pop_cmp(input int n);
        logic [EWT-1:0] e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("out_data lane%0d", i), 64'(out_data[i*EWT +: EWT]), 64'(e));
        end
    endtask

    task automatic push_model(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(in_data[i*EWT +: EWT]);
        end
    endtask

    // Called at the falling edge, after inputs settle and before the rising edge commits them.
    task automatic model_step();
        int         size;
        bit         ready;
        bit         byp;
        logic [1:0] ev;
        int         npush;
        int         npop;
        bit         err;
        size  = exp_q.size();
        ready = size <= DEPTH - LANES;
        byp   = BYP && size == 0 && !flush;
        ev    = byp ? thermo(lo2(in_valid)) : thermo(size);
        npush = ready ? lo2(in_valid) : 0;
        npop  = lo2(out_take & ev);
        chk("count", 64'(count), 64'(size));
        chk("in_ready", 64'(in_ready), 64'(ready));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("proto_err", 64'(proto_err), 64'(perr));
        err = (ready && in_valid == 2'b10) || out_take == 2'b10 || ((out_take & ~ev) != 2'b00);
        $display("cyc v=%b t=%b f=%b count=%0d ready=%b ov=%b perr=%b npush=%0d npop=%0d",
                 in_valid, out_take, flush, count, in_ready, out_valid, proto_err, npush, npop);
        if (flush) begin
            exp_q.delete();
        end else if (byp) begin
            push_model(npush);
            pop_cmp(npop);
        end else begin
            pop_cmp(npop);
            push_model(npush);
        end
        perr    = perr | err;
        next_pc = next_pc + 2'd2;
    endtask

    task automatic cycle(input logic [1:0] v, input logic [1:0] t, input logic f);
        apply(v, t, f);
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // Fill to full, drop a push, drain, then push 2 / take 1 at count 3.
        tab[0] = '{2'b11, 2'b00, 1'b0, 0, 1'b1};
        tab[1] = '{2'b11, 2'b00, 1'b0, 2, 1'b1};
        tab[2] = '{2'b11, 2'b00, 1'b0, 4, 1'b1};
        tab[3] = '{2'b11, 2'b00, 1'b0, 6, 1'b1};
        tab[4] = '{2'b11, 2'b00, 1'b0, 8, 1'b0};
        tab[5] = '{2'b00, 2'b11, 1'b0, 8, 1'b0};
        tab[6] = '{2'b00, 2'b11, 1'b0, 6, 1'b1};
        tab[7] = '{2'b00, 2'b01, 1'b0, 4, 1'b1};
        tab[8] = '{2'b11, 2'b01, 1'b0, 3, 1'b1};
        tab[9] = '{2'b00, 2'b00, 1'b0, 4, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 64'(count), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset proto_err", 64'(proto_err), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 10; r++) begin
            apply(tab[r].v, tab[r].t, tab[r].f);
            @(negedge clk);
            chk($sformatf("tab%0d count", r), 64'(count), 64'(tab[r].cnt));
            chk($sformatf("tab%0d in_ready", r), 64'(in_ready), 64'(tab[r].rdy));
            model_step();
            @(posedge clk);
            #1;
        end

        // Steady push/take across pointer wrap.
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(2'b11, 2'b11, 1'b0);
        end

        // Flush at count 5 with a simultaneous push and take.
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 1'b0);
        chk("pre-flush count", 64'(count), 64'd5);
        cycle(2'b11, 2'b11, 1'b1);
        chk("post-flush count", 64'(count), 64'd0);
        chk("post-flush out_valid", 64'(out_valid), 64'd0);
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b00, 2'b11, 1'b0);

`ifdef FIB_BYPASS_EN
        // Empty queue: lane 0 is consumed in the same cycle, lane 1 is stored.
        cycle(2'b11, 2'b01, 1'b0);
        chk("bypass count", 64'(count), 64'd1);
        cycle(2'b00, 2'b01, 1'b0);
`endif

        // Take that skips lane 0 is a protocol error and pops nothing.
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b00, 2'b10, 1'b0);
        chk("bad take count", 64'(count), 64'd2);
        chk("bad take proto_err", 64'(proto_err), 64'd1);
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b01, 1'b0);

        // Asynchronous reset in the middle of a fill.
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        chk("prefill count", 64'(count), 64'(exp_q.size()));
        #2;
        rst = 1'b0;
        #1;
        chk("async rst count", 64'(count), 64'd0);
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        chk("async rst proto_err", 64'(proto_err), 64'd0);
        exp_q.delete();
        perr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Non-thermometer push is dropped and flagged.
        cycle(2'b10, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b00, 2'b11, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
